// File: rtl/cpu_nios2_gen2_0_cpu_debug_host_shifter_pkg.sv
// Shared types and constants for the debug host shifter.
// Holds the default DR length, IR width and the shifter FSM state enum.
package cpu_nios2_gen2_0_cpu_debug_host_shifter_pkg;

  localparam int DR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH         = 2;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RSP
  } state_t;

endpackage

// File: rtl/cpu_nios2_gen2_0_cpu_debug_host_tck_gen.sv
// Virtual TCK generator: TCK_DIV clk low, TCK_DIV clk high, while i_en.
// Ports: clk, reset_n, i_en; o_tck, o_rise (tck goes high), o_fall (goes low).
module cpu_nios2_gen2_0_cpu_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  output logic o_tck,
  output logic o_rise,
  output logic o_fall
);

  logic [7:0] r_cnt;
  logic       r_tck;
  logic       w_end;

  assign w_end = (r_cnt == 8'(TCK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_tck <= 1'b0;
    end else if (w_end) begin
      r_cnt <= '0;
      r_tck <= ~r_tck;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Strobes mark the clk edge on which tck toggles.
  assign o_tck  = r_tck;
  assign o_rise = i_en & w_end & ~r_tck;
  assign o_fall = i_en & w_end & r_tck;

endmodule

// File: rtl/cpu_nios2_gen2_0_cpu_debug_host_shifter.sv
// Host-side virtual-JTAG shifter: runs UIR/CDR/SDR/UDR per command word.
// Ports: cmd_* in, rsp_* out (valid/ready), vji_* drive the debug slave.
module cpu_nios2_gen2_0_cpu_debug_host_shifter
  import cpu_nios2_gen2_0_cpu_debug_host_shifter_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo
);

  localparam int BW = $clog2(DR_WIDTH + 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_pend;
  logic [IR_WIDTH-1:0]   r_ir;
  logic [DR_WIDTH-1:0]   r_dr;
  logic [DR_WIDTH-1:0]   r_cap;
  logic [BW-1:0]         r_bit;
  logic                  w_run;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_sdr;

  assign w_run = (r_state == UIR) || (r_state == CDR) ||
                 (r_state == SDR) || (r_state == UDR);
  assign w_sdr = (r_state == SDR);
  assign w_last = (r_bit == BW'(DR_WIDTH - 1));
  // One settle cycle after accept before UIR starts.
  assign cmd_ready = (r_state == IDLE) && !r_pend;
  assign w_accept = cmd_valid && cmd_ready;

  cpu_nios2_gen2_0_cpu_debug_host_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_run),
    .o_tck   (vji_tck),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (r_pend) w_next = UIR;
      UIR:  if (w_fall) w_next = CDR;
      CDR:  if (w_fall) w_next = SDR;
      SDR:  if (w_fall && w_last) w_next = UDR;
      UDR:  if (w_fall) w_next = RSP;
      RSP:  if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_ir    <= '0;
      r_dr    <= '0;
      r_cap   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= w_accept;
      if (w_accept) begin
        r_ir <= cmd_ir;
        r_dr <= cmd_data;
      end else if (w_sdr && w_fall) begin
        r_dr <= r_dr >> 1;
      end
      if (!w_sdr) begin
        r_bit <= '0;
      end else if (w_fall) begin
        r_bit <= r_bit + BW'(1);
      end
      // First sampled bit walks down to bit 0.
      if (w_sdr && w_rise) begin
        r_cap <= {vji_tdo, r_cap[DR_WIDTH-1:1]};
      end
    end
  end

  assign rsp_valid = (r_state == RSP);
  assign rsp_data  = r_cap;
  assign vji_tdi   = w_sdr & r_dr[0];
  assign vji_uir   = (r_state == UIR);
  assign vji_cdr   = (r_state == CDR);
  assign vji_sdr   = w_sdr;
  assign vji_udr   = (r_state == UDR);
  assign vji_rti   = (r_state == IDLE);
  assign vji_ir_in = w_run ? r_ir : 2'b00;

endmodule

// File: tb/tb_cpu_nios2_gen2_0_cpu_debug_host_shifter.sv
// Bench for the debug host shifter with a behavioural DR slave model.
// Checks framing, data, latency, backpressure, abort and reset.
module tb_cpu_nios2_gen2_0_cpu_debug_host_shifter;

  localparam int W    = 38;
  localparam int LAT  = 2 * 2 * (W + 3) + 1;
  localparam int LATF = 2 * 1 * (W + 3) + 1;

  logic         clk;
  logic         reset_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_ir;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         vji_tck, vji_tdi, vji_uir, vji_cdr;
  logic         vji_sdr, vji_udr, vji_rti;
  logic [1:0]   vji_ir_in;
  logic         vji_tdo;

  logic         f_cmd_valid, f_cmd_ready;
  logic [1:0]   f_cmd_ir;
  logic [W-1:0] f_cmd_data;
  logic         f_rsp_valid, f_rsp_ready;
  logic [W-1:0] f_rsp_data;
  logic         f_tck, f_tdi, f_uir, f_cdr, f_sdr, f_udr, f_rti;
  logic [1:0]   f_ir_in;
  logic         f_tdo;

  int n_chk = 0;
  int n_err = 0;

  cpu_nios2_gen2_0_cpu_debug_host_shifter #(
    .TCK_DIV(2), .DR_WIDTH(W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_uir(vji_uir),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr),
    .vji_rti(vji_rti), .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo)
  );

  cpu_nios2_gen2_0_cpu_debug_host_shifter #(
    .TCK_DIV(1), .DR_WIDTH(W)
  ) dut_fast (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
    .rsp_data(f_rsp_data),
    .vji_tck(f_tck), .vji_tdi(f_tdi), .vji_uir(f_uir),
    .vji_cdr(f_cdr), .vji_sdr(f_sdr), .vji_udr(f_udr),
    .vji_rti(f_rti), .vji_ir_in(f_ir_in), .vji_tdo(f_tdo)
  );

  // Fast instance loops tdi back to tdo: it must capture its own word.
  assign f_tdo = f_tdi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: a W-bit shift register clocked by tck while in SDR.
  logic [W-1:0] sr;
  logic [W-1:0] load_val;
  logic         load;
  logic         load_sr;
  logic [1:0]   cur_ir;
  logic         tdi_q[$];
  int n_uir, n_cdr, n_sdr, n_udr, n_irbad;

  assign vji_tdo = sr[0];

  always @(posedge vji_tck or posedge load) begin
    if (load) begin
      if (load_sr) sr <= load_val;
      n_uir   <= 0;
      n_cdr   <= 0;
      n_sdr   <= 0;
      n_udr   <= 0;
      n_irbad <= 0;
      tdi_q.delete();
    end else begin
      if (vji_uir) n_uir <= n_uir + 1;
      if (vji_cdr) n_cdr <= n_cdr + 1;
      if (vji_udr) n_udr <= n_udr + 1;
      if (vji_sdr) begin
        tdi_q.push_back(vji_tdi);
        sr    <= {vji_tdi, sr[W-1:1]};
        n_sdr <= n_sdr + 1;
      end
      if (vji_ir_in !== cur_ir) n_irbad <= n_irbad + 1;
    end
  end

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom, $urandom});
  endfunction

  task automatic slave_clear(input bit set_sr, input logic [W-1:0] v);
    load_sr  = set_sr;
    load_val = v;
    load     = 1'b1;
    #1;
    load     = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] ir, input logic [W-1:0] d,
                         input logic [W-1:0] exp, input int hold,
                         input bit busy, input string nm);
    int k;
    int bad;
    int rdy_busy;
    logic [W-1:0] got;
    logic [W-1:0] held;
    cur_ir = ir;
    rdy_busy = 0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s cmd_ready idle: got %b want 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_ir    = 2'($urandom);
    cmd_data  = rnd_word();
    for (k = 1; k < 2000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) break;
      if (cmd_ready) rdy_busy++;
      if (busy) begin
        if (k == 10) begin
          cmd_valid = 1'b1;
          cmd_data  = ~d;
        end
        if (k == 60) cmd_valid = 1'b0;
        rsp_ready = (k == 30);
      end
    end
    n_chk++;
    if (k != LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d want %0d", nm, k, LAT);
    end
    n_chk++;
    if (rdy_busy != 0) begin
      n_err++;
      $display("FAIL %s cmd_ready busy: got %0d cycles want 0", nm, rdy_busy);
    end
    n_chk++;
    if (rsp_data !== exp) begin
      n_err++;
      $display("FAIL %s rsp_data: got %h want %h", nm, rsp_data, exp);
    end
    got = '0;
    for (int i = 0; i < tdi_q.size() && i < W; i++) got[i] = tdi_q[i];
    n_chk++;
    if (tdi_q.size() != W || got !== d) begin
      n_err++;
      $display("FAIL %s tdi: got %h (%0d bits) want %h (%0d bits)",
               nm, got, tdi_q.size(), d, W);
    end
    n_chk++;
    if (n_uir != 1 || n_cdr != 1 || n_sdr != W || n_udr != 1) begin
      n_err++;
      $display("FAIL %s framing: got uir=%0d cdr=%0d sdr=%0d udr=%0d want 1 1 %0d 1",
               nm, n_uir, n_cdr, n_sdr, n_udr, W);
    end
    n_chk++;
    if (n_irbad != 0) begin
      n_err++;
      $display("FAIL %s ir_in: got %0d bad rises want 0", nm, n_irbad);
    end
    held = rsp_data;
    bad  = 0;
    for (int j = 0; j < hold; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) bad++;
    end
    if (hold > 0) begin
      n_chk++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL %s backpressure: got %0d bad cycles want 0", nm, bad);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    n_chk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vji_rti !== 1'b1 ||
        vji_ir_in !== 2'b00 || vji_tck !== 1'b0) begin
      n_err++;
      $display("FAIL %s release: got rdy=%b vld=%b rti=%b ir=%b tck=%b want 1 0 1 00 0",
               nm, cmd_ready, rsp_valid, vji_rti, vji_ir_in, vji_tck);
    end
  endtask

  task automatic check_reset_outs(input string nm);
    n_chk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
      n_err++;
      $display("FAIL %s handshake: got rdy=%b vld=%b data=%h want 1 0 0",
               nm, cmd_ready, rsp_valid, rsp_data);
    end
    n_chk++;
    if ({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr} !== 6'b0 ||
        vji_rti !== 1'b1 || vji_ir_in !== 2'b00) begin
      n_err++;
      $display("FAIL %s vji: got tck=%b tdi=%b u=%b c=%b s=%b d=%b rti=%b ir=%b",
               nm, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr,
               vji_rti, vji_ir_in);
    end
  endtask

  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    #2;
    check_reset_outs("reset_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset_held");
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    slave_clear(1'b1, '0);
    run_cmd(2'b01, 38'h2A_5555_AAAA, '0, 10, 1'b0, "basic1");
    slave_clear(1'b0, '0);
    run_cmd(2'($urandom), rnd_word(), 38'h2A_5555_AAAA, 0, 1'b0, "basic2");
  endtask

  task automatic test_random();
    logic [W-1:0] prev;
    logic [W-1:0] d;
    prev = rnd_word();
    slave_clear(1'b1, prev);
    for (int i = 0; i < 4; i++) begin
      d = rnd_word();
      slave_clear(1'b0, '0);
      run_cmd(2'($urandom), d, prev, int'($urandom_range(0, 5)), 1'b0, "random");
      prev = d;
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] v;
    logic [W-1:0] d;
    v = rnd_word();
    d = rnd_word();
    slave_clear(1'b1, v);
    run_cmd(2'b11, d, v, 3, 1'b1, "busy");
    n_chk++;
    if (sr !== d) begin
      n_err++;
      $display("FAIL busy slave_dr: got %h want %h", sr, d);
    end
  endtask

  task automatic test_abort();
    int k;
    int vld;
    logic [W-1:0] v;
    slave_clear(1'b1, rnd_word());
    cur_ir = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir    = 2'b10;
    cmd_data  = rnd_word();
    @(negedge clk);
    cmd_valid = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (n_sdr >= 20) break;
    end
    n_chk++;
    if (n_sdr != 20) begin
      n_err++;
      $display("FAIL abort reach_bit20: got %0d want 20", n_sdr);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outs("abort_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vld = 0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid) vld++;
    end
    n_chk++;
    if (vld != 0) begin
      n_err++;
      $display("FAIL abort no_rsp: got %0d valid cycles want 0", vld);
    end
    v = rnd_word();
    slave_clear(1'b1, v);
    run_cmd(2'b01, rnd_word(), v, 2, 1'b0, "after_abort");
  endtask

  task automatic test_latency_fast();
    int k;
    logic [W-1:0] d;
    d = rnd_word();
    @(negedge clk);
    f_cmd_valid = 1'b1;
    f_cmd_ir    = 2'b01;
    f_cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    f_cmd_valid = 1'b0;
    for (k = 1; k < 1000; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (f_rsp_valid) break;
    end
    n_chk++;
    if (k != LATF) begin
      n_err++;
      $display("FAIL fast latency: got %0d want %0d", k, LATF);
    end
    n_chk++;
    if (f_rsp_data !== d) begin
      n_err++;
      $display("FAIL fast loopback: got %h want %h", f_rsp_data, d);
    end
    f_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f_rsp_ready = 1'b0;
    n_chk++;
    if (f_cmd_ready !== 1'b1 || f_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fast release: got rdy=%b vld=%b want 1 0",
               f_cmd_ready, f_rsp_valid);
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    cmd_valid   = 1'b0;
    cmd_ir      = 2'b00;
    cmd_data    = '0;
    rsp_ready   = 1'b0;
    f_cmd_valid = 1'b0;
    f_cmd_ir    = 2'b00;
    f_cmd_data  = '0;
    f_rsp_ready = 1'b0;
    load        = 1'b0;
    load_sr     = 1'b0;
    load_val    = '0;
    cur_ir      = 2'b00;
    sr          = '0;
    test_reset();
    test_basic();
    test_random();
    test_busy_ignore();
    test_abort();
    test_latency_fast();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_nios2_gen2_0_cpu_debug_host_shifter.md
CPU_NIOS2_GEN2_0_CPU_DEBUG_HOST_SHIFTER -- requirements
Module: cpu_nios2_gen2_0_cpu_debug_host_shifter

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2, giving the clk cycles per vji_tck phase (legal range 1..255).
REQ-002 SHALL have parameter DR_WIDTH, default 38, giving the data-register length in bits.
REQ-003 SHALL have port clk  in  1  the single clock for all logic.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_ir  in  2  virtual IR value.
REQ-008 SHALL have port cmd_data  in  DR_WIDTH  DR word to shift out.
REQ-009 SHALL have port rsp_valid  out  1  captured word available.
REQ-010 SHALL have port rsp_ready  in  1  captured word consumed.
REQ-011 SHALL have port rsp_data  out  DR_WIDTH  word captured from vji_tdo.
REQ-012 SHALL have ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each; vji_ir_in  out  2; vji_tdo  in  1; these drive the debug slave's virtual-JTAG inputs.

Function
REQ-013 SHALL implement FSM states IDLE, UIR, CDR, SDR, UDR and RSP.
REQ-014 SHALL assert cmd_ready only in IDLE; on accept SHALL latch cmd_ir and cmd_data and enter UIR on the next clk.
REQ-015 SHALL define one tck period as TCK_DIV clk cycles with vji_tck low followed by TCK_DIV clk cycles with vji_tck high; vji_tck SHALL be held low in IDLE and RSP.
REQ-016 SHALL spend exactly one tck period in each of UIR, CDR and UDR, and exactly DR_WIDTH tck periods in SDR; transitions SHALL occur only at the end of a high phase.
REQ-017 SHALL assert each of vji_uir, vji_cdr, vji_sdr and vji_udr high exactly while in its matching state; vji_rti SHALL be high only in IDLE.
REQ-018 SHALL drive vji_ir_in with the latched IR from UIR through UDR inclusive, and 2'b00 otherwise.
REQ-019 In SDR, SHALL drive vji_tdi LSB-first, changing only at the start of a low phase; vji_tdi SHALL be 0 outside SDR.
REQ-020 SHALL sample vji_tdo on the clk where vji_tck rises in SDR and shift it into the capture register MSB-first, so that the first sampled bit ends in bit 0.
REQ-021 After UDR, SHALL enter RSP with rsp_valid high and rsp_data stable; rsp_valid first rises exactly 2*TCK_DIV*(DR_WIDTH+3)+1 clk cycles after the accepting edge (165 cycles at the defaults).
REQ-022 SHALL hold rsp_valid and rsp_data until rsp_ready is high, then return to IDLE on the next clk; cmd_ready SHALL be low throughout RSP.
REQ-023 SHALL ignore cmd_valid while not in IDLE.
REQ-024 SHALL treat rsp_ready high before rsp_valid as having no effect.

Reset
REQ-025 SHALL, on reset_n low at any time including mid-shift, immediately drive: state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, vji_tck=0, vji_tdi=0, vji_uir=vji_cdr=vji_sdr=vji_udr=0, vji_rti=1, vji_ir_in=0.
REQ-026 SHALL clear the phase counter, bit counter, latched command and capture register on reset, and SHALL not produce a response for an aborted command.

Structure
REQ-027 SHALL have a shared package holding DR_WIDTH_DEFAULT=38, IR_WIDTH=2 and the FSM state enum.
REQ-028 SHALL place vji_tck generation, the phase counter and the rise/fall tick strobes in one sub-module, cpu_nios2_gen2_0_cpu_debug_host_tck_gen.

Verification
REQ-029 SHALL cover reset: assert reset_n=0 mid-run -> all outputs match REQ-025 within the same cycle, without waiting for clk.
REQ-030 SHALL cover a command with ir=2'b01, data=38'h2A_5555_AAAA into a 38-bit shift-register slave model preloaded with 0 -> tdi bit sequence 0,1,0,1,... LSB-first; rsp_data=0; a second command returns 38'h2A_5555_AAAA.
REQ-031 SHALL cover framing: count tck rising edges per flag -> uir=1, cdr=1, sdr=38, udr=1, with vji_ir_in=2'b01 stable across all of them.
REQ-032 SHALL cover backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_data stable and cmd_ready=0 throughout; IDLE is entered one clk after rsp_ready=1.
REQ-033 SHALL cover abort: apply reset at the 20th SDR bit, then issue a new command -> no rsp_valid for the aborted command; the new command completes normally.
REQ-034 SHALL cover latency: TCK_DIV=1 -> rsp_valid first rises 83 clk cycles after the accept edge.
